// File: rtl/faccel_sched_pkg.sv
// faccel_pkg: shared types and bus constants for the factorial accelerator scheduler
package faccel_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WR_N, S_WR_GO, S_POLL, S_RD, S_RESP} sched_state_t;
   localparam logic [1:0] A_N  = 2'b00;
   localparam logic [1:0] A_GO = 2'b01;
   localparam logic [1:0] A_ST = 2'b10;
   localparam logic [1:0] A_NF = 2'b11;
   localparam logic [3:0] GO_CMD = 4'b0001;
endpackage

// File: rtl/faccel_sched_if.sv
// faccel_sched_if: client request/ack bundle plus the accelerator we/a/d/out bus
interface faccel_sched_if;
   logic [1:0]  req;
   logic [3:0]  n0;
   logic [3:0]  n1;
   logic [1:0]  ack;
   logic [31:0] result;
   logic        err;
   logic        busy;
   logic        acc_we;
   logic [1:0]  acc_a;
   logic [3:0]  acc_d;
   logic [31:0] acc_out;
   modport master (input req, n0, n1, acc_out, output ack, result, err, busy, acc_we, acc_a, acc_d);
   modport slave (output req, n0, n1, acc_out, input ack, result, err, busy, acc_we, acc_a, acc_d);
endinterface

// File: rtl/faccel_sched_arb.sv
// rr_arb2: combinational two-way round-robin pick; a tie goes to whoever was not served last
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);
   assign gnt_valid = |req;
   assign gnt_idx   = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/faccel_sched.sv
// faccel_sched: round-robin client scheduler for the factorial accelerator; FACCEL_SCHED_TIMEOUT_EN adds a POLL timeout
module faccel_sched
   import faccel_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input logic           Clk,
   input logic           Rst_n,
   faccel_sched_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   sched_state_t r_state, w_next;
   logic        r_g, r_last;
   logic [3:0]  r_n;
   logic [31:0] r_result;
   logic        w_gv, w_gi, w_timeout;
   rr_arb2 u_arb (.req(bus.req), .last(r_last), .gnt_valid(w_gv), .gnt_idx(w_gi));
`ifdef FACCEL_SCHED_TIMEOUT_EN
   logic [TW-1:0] r_cnt;
   logic          r_err;
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= (r_state == S_WR_GO) ? '0 : (r_state == S_POLL) ? r_cnt + 1'b1 : r_cnt;
         r_err <= (r_state == S_IDLE && w_gv) ? 1'b0 : (w_timeout ? 1'b1 : r_err);
      end
   end
   assign w_timeout = (r_state == S_POLL) && !bus.acc_out[0] && (r_cnt == TW'(TIMEOUT - 1));
   assign bus.err   = r_err;
`else
   logic [TW-1:0] w_unused_to;
   assign w_unused_to = TW'(TIMEOUT);
   assign w_timeout   = 1'b0;
   assign bus.err     = 1'b0;
`endif
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_gv ? S_WR_N : S_IDLE;
         S_WR_N:  w_next = S_WR_GO;
         S_WR_GO: w_next = S_POLL;
         S_POLL:  w_next = bus.acc_out[0] ? S_RD : (w_timeout ? S_RESP : S_POLL);
         S_RD:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_g      <= 1'b0;
         r_last   <= 1'b1;
         r_n      <= '0;
         r_result <= '0;
      end else begin
         if (r_state == S_IDLE && w_gv) begin
            r_g <= w_gi;
            r_n <= w_gi ? bus.n1 : bus.n0;
         end
         if (r_state == S_RD) r_result <= bus.acc_out;
         if (w_timeout)       r_result <= '0;
         if (r_state == S_RESP) r_last <= r_g;
      end
   end
   // An odd N write also kicks the accelerator; the WR_GO that always follows restarts it with the right N.
   assign bus.acc_we = (r_state == S_WR_N) || (r_state == S_WR_GO);
   assign bus.acc_a  = (r_state == S_WR_GO) ? A_GO : (r_state == S_POLL) ? A_ST : (r_state == S_RD) ? A_NF : A_N;
   assign bus.acc_d  = (r_state == S_WR_N) ? r_n : (r_state == S_WR_GO) ? GO_CMD : 4'b0000;
   assign bus.ack    = (r_state == S_RESP) ? {r_g, ~r_g} : 2'b00;
   assign bus.result = r_result;
   assign bus.busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_faccel_sched.sv
// tb_faccel_sched: directed checks of faccel_sched against a small accelerator model
module tb_faccel_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   int lat = 0;
   logic stub = 1'b0;
   logic [3:0] m_n, m_src;
   logic [7:0] m_cnt;
   logic m_st;
   logic [1:0] we_a [2];
   logic [3:0] we_d [2];
   int nwe, npoll;
   int k;
   logic [1:0] av;
   logic [31:0] rv;
   logic ev;
   faccel_sched_if bus ();
   faccel_sched #(.TIMEOUT(8)) dut (.Clk(clk), .Rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] fact(input logic [3:0] n);
      logic [31:0] r = 32'd1;
      for (int i = 2; i <= int'(n); i++) r = r * i;
      return r;
   endfunction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n <= '0; m_src <= '0; m_cnt <= '0; m_st <= 1'b0;
      end else begin
         if (bus.acc_we && bus.acc_a == 2'b00) m_n <= bus.acc_d;
         if (bus.acc_we && bus.acc_d[0]) begin
            m_src <= m_n;
            m_cnt <= 8'(lat);
            m_st  <= (lat == 0);
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1'b1;
            if (m_cnt == 8'd1) m_st <= 1'b1;
         end
      end
   end
   assign bus.acc_out = stub ? 32'd0 :
                        (bus.acc_a == 2'b10) ? {31'd0, m_st} :
                        (bus.acc_a == 2'b11) ? fact(m_src) :
                        (bus.acc_a == 2'b00) ? {28'd0, m_n} : 32'd0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic wait_ack();
      k = 0; av = 2'b00; nwe = 0; npoll = 0;
      while (av == 2'b00 && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (bus.acc_we) begin
            if (nwe < 2) begin we_a[nwe] = bus.acc_a; we_d[nwe] = bus.acc_d; end
            nwe++;
         end
         if (bus.acc_a == 2'b10) npoll++;
         av = bus.ack; rv = bus.result; ev = bus.err;
      end
      chk("ack_seen", {31'd0, av != 2'b00}, 32'd1);
   endtask
   task automatic do_reset();
      bus.req = 2'b00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.req = 2'b00; bus.n0 = '0; bus.n1 = '0;
      do_reset();
      chk("rst_ack", {30'd0, bus.ack}, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_err", {31'd0, bus.err}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_we", {31'd0, bus.acc_we}, 0);
      chk("rst_a", {30'd0, bus.acc_a}, 0);
      chk("rst_d", {28'd0, bus.acc_d}, 0);
      // single job with accelerator latency 3: ack at 5+3
      lat = 3; bus.n0 = 4'd5; bus.req = 2'b01;
      wait_ack();
      bus.req = 2'b00;
      chk("j5_ack", {30'd0, av}, 1);
      chk("j5_result", rv, 120);
      chk("j5_err", {31'd0, ev}, 0);
      chk("j5_latency", k, 8);
      @(posedge clk); #1;
      chk("j5_ack_pulse", {30'd0, bus.ack}, 0);
      chk("j5_idle", {31'd0, bus.busy}, 0);
      // zero-latency job: minimum latency and write sequence
      lat = 0; bus.n0 = 4'd3; bus.req = 2'b01;
      wait_ack();
      bus.req = 2'b00;
      chk("j3_result", rv, 6);
      chk("j3_latency", k, 5);
      chk("j3_we_count", nwe, 2);
      chk("j3_we_a0", {30'd0, we_a[0]}, 0);
      chk("j3_we_a1", {30'd0, we_a[1]}, 1);
      chk("j3_we_d0", {28'd0, we_d[0]}, 3);
      chk("j3_we_d1", {28'd0, we_d[1]}, 1);
      chk("j3_polls", npoll, 1);
      // tie from reset: requester 0 first
      do_reset();
      bus.n0 = 4'd3; bus.n1 = 4'd4; bus.req = 2'b11;
      wait_ack();
      bus.req = 2'b10;
      chk("tie_first_ack", {30'd0, av}, 1);
      chk("tie_first_result", rv, 6);
      wait_ack();
      chk("tie_second_ack", {30'd0, av}, 2);
      chk("tie_second_result", rv, 24);
      chk("tie_spacing", k, 6);
      // continuous re-requests alternate
      bus.n0 = 4'd0; bus.n1 = 4'd0; bus.req = 2'b11;
      for (int j = 0; j < 4; j++) begin
         wait_ack();
         chk("alt_ack", {30'd0, av}, (j % 2 == 0) ? 32'd1 : 32'd2);
         chk("alt_result", rv, 1);
         chk("alt_spacing", k, 6);
      end
      bus.req = 2'b00;
      @(posedge clk); #1;
      // reset during POLL
      lat = 10; bus.n0 = 4'd6; bus.req = 2'b01;
      k = 0;
      while (bus.acc_a != 2'b10 && k < 20) begin @(posedge clk); #1; k++; end
      chk("reach_poll", {30'd0, bus.acc_a}, 2);
      @(posedge clk); #2;
      rst_n = 1'b0; bus.req = 2'b00;
      #1;
      chk("mid_rst_ack", {30'd0, bus.ack}, 0);
      chk("mid_rst_result", bus.result, 0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 0);
      chk("mid_rst_we", {31'd0, bus.acc_we}, 0);
      chk("mid_rst_a", {30'd0, bus.acc_a}, 0);
      chk("mid_rst_d", {28'd0, bus.acc_d}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("mid_rst_no_ack", {30'd0, bus.ack}, 0);
      end
      lat = 0; bus.n0 = 4'd2; bus.req = 2'b01;
      wait_ack();
      bus.req = 2'b00;
      chk("post_rst_result", rv, 2);
      chk("post_rst_ack", {30'd0, av}, 1);
`ifdef FACCEL_SCHED_TIMEOUT_EN
      @(posedge clk); #1;
      stub = 1'b1; bus.n0 = 4'd5; bus.req = 2'b01;
      wait_ack();
      bus.req = 2'b00;
      chk("to_err", {31'd0, ev}, 1);
      chk("to_result", rv, 0);
      chk("to_polls", npoll, 8);
      chk("to_latency", k, 11);
      @(posedge clk); #1;
      stub = 1'b0; bus.n0 = 4'd4; bus.req = 2'b01;
      wait_ack();
      bus.req = 2'b00;
      chk("after_to_result", rv, 24);
      chk("after_to_err", {31'd0, ev}, 0);
`endif
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
